// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//
// Control and timekeeping stage for the stopwatch. Turns the debounced button
// levels into single-cycle press events, runs an IDLE/RUN/PAUSE state machine,
// divides clk down to a 100 Hz tick while running and advances a mm:ss.cc BCD
// time counter.
//
// Optional feature: define STOPWATCH_LAP_EN to enable the lap (display freeze)
// function. Without it the lap input is unused and lap_active is tied to 0.
//
// Parameters:
//   TICK_DIV    clk cycles per hundredth of a second (>= 2)
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   start_stop  debounced start/stop button level
//   clear       debounced clear button level
//   lap         debounced lap button level (only used with STOPWATCH_LAP_EN)
//   running     high while in RUN
//   digits      BCD time: [23:20] min tens, [19:16] min ones, [15:12] sec tens,
//               [11:8] sec ones, [7:4] centisec tens, [3:0] centisec ones
//   wrap        one-cycle pulse when the counter rolls over 59:59.99 -> 00:00.00
//   lap_active  high while the display is frozen on a lap value
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic        running,
    output logic [23:0] digits,
    output logic        wrap,
    output logic        lap_active
);

    localparam int unsigned PresWidth = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PresWidth-1:0] PresLast = PresWidth'(TICK_DIV - 1);

    // Highest value of each BCD digit, least significant digit in [3:0].
    localparam logic [23:0] DigMax = 24'h595999;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause
    } state_e;

    state_e                 state_q, state_d;
    logic [PresWidth-1:0]   pres_q, pres_d;
    logic [23:0]            cnt_q, cnt_d;
    logic                   wrap_q, wrap_d;
    logic                   ss_prev_q, clr_prev_q;

    logic                   ss_press;
    logic                   clr_press;
    logic                   do_clear;
    logic                   tick;
    logic                   carry;
    logic [3:0]             dig;

    // Previous-level registers reset to 1 so a button held through reset
    // does not register as a press once reset is released.
    assign ss_press  = start_stop & ~ss_prev_q;
    assign clr_press = clear & ~clr_prev_q;

    assign running = (state_q == StRun);
    assign tick    = (pres_q == PresLast) && (state_q == StRun);
    assign wrap    = wrap_q;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        do_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ss_press) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Clear is ignored while running.
                if (ss_press) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                // Clear has priority over start_stop when both arrive together.
                if (clr_press) begin
                    state_d  = StIdle;
                    do_clear = 1'b1;
                end else if (ss_press) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Prescaler: held outside RUN so a paused partial hundredth is kept.
    // ------------------------------------------------------------------
    always_comb begin
        pres_d = pres_q;
        if (do_clear) begin
            pres_d = '0;
        end else if (tick) begin
            pres_d = '0;
        end else if (state_q == StRun) begin
            pres_d = pres_q + PresWidth'(1);
        end
    end

    // ------------------------------------------------------------------
    // BCD time counter with a single-cycle ripple carry chain. The carry out
    // of the minutes-tens digit is the rollover indication.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        carry  = 1'b0;
        dig    = 4'd0;
        if (do_clear) begin
            cnt_d = '0;
        end else if (tick) begin
            carry = 1'b1;
            for (int i = 0; i < 6; i++) begin
                dig = cnt_q[4*i +: 4];
                if (carry) begin
                    if (dig == DigMax[4*i +: 4]) begin
                        cnt_d[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_d[4*i +: 4] = dig + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pres_q     <= '0;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            ss_prev_q  <= 1'b1;
            clr_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pres_q     <= pres_d;
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            ss_prev_q  <= start_stop;
            clr_prev_q <= clear;
        end
    end

    // ------------------------------------------------------------------
    // Lap display freeze
    // ------------------------------------------------------------------
`ifdef STOPWATCH_LAP_EN
    logic        lap_prev_q;
    logic        lap_q, lap_d;
    logic [23:0] disp_q, disp_d;
    logic        lap_press;
    logic        lap_toggle;

    assign lap_press  = lap & ~lap_prev_q;
    // Lap presses only count once the stopwatch has been started.
    assign lap_toggle = lap_press && (state_q != StIdle);

    always_comb begin
        lap_d  = lap_q;
        disp_d = disp_q;
        if (do_clear) begin
            lap_d = 1'b0;
        end else if (lap_toggle) begin
            lap_d = ~lap_q;
            // Snapshot the counter as it stands at the press.
            if (!lap_q) begin
                disp_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_prev_q <= 1'b1;
            lap_q      <= 1'b0;
            disp_q     <= '0;
        end else begin
            lap_prev_q <= lap;
            lap_q      <= lap_d;
            disp_q     <= disp_d;
        end
    end

    assign lap_active = lap_q;
    assign digits     = lap_q ? disp_q : cnt_q;
`else
    logic unused_lap;
    assign unused_lap = lap;

    assign lap_active = 1'b0;
    assign digits     = cnt_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with TICK_DIV=4. Inputs change just
// after the falling edge and outputs are sampled there, half a period away
// from the active rising edge.
module tb_stopwatch_ctrl;

    logic        clk;
    logic        reset;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic        running;
    logic [23:0] digits;
    logic        wrap;
    logic        lap_active;

    int unsigned n_checks;
    int unsigned n_bad;

    stopwatch_ctrl #(
        .TICK_DIV (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .running    (running),
        .digits     (digits),
        .wrap       (wrap),
        .lap_active (lap_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge with the button high; returns just after that edge.
    task automatic press_ss();
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
    endtask

    task automatic press_clr();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    task automatic press_both();
        start_stop = 1'b1;
        clear      = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic press_lap();
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_bad      = 0;
        reset      = 1'b1;
        start_stop = 1'b1;
        clear      = 1'b0;
        lap        = 1'b0;

        // Reset with start_stop held, then keep it held after reset.
        cyc(3);
        check_eq("rst_running", 32'(running), 32'd0);
        check_eq("rst_digits", 32'(digits), 32'h000000);
        check_eq("rst_wrap", 32'(wrap), 32'd0);
        check_eq("rst_lap_active", 32'(lap_active), 32'd0);
        reset = 1'b0;
        cyc(5);
        check_eq("held_ss_running", 32'(running), 32'd0);
        check_eq("held_ss_digits", 32'(digits), 32'h000000);
        start_stop = 1'b0;
        cyc(1);

        // Clear in IDLE does nothing.
        press_clr();
        cyc(1);
        check_eq("idle_clr_running", 32'(running), 32'd0);

        // start_stop held 10 cycles: one press (edge N).
        start_stop = 1'b1;
        cyc(1);                                   // after N
        check_eq("start_running", 32'(running), 32'd1);
        check_eq("start_digits", 32'(digits), 32'h000000);
        cyc(3);                                   // after N+3
        check_eq("pre_tick_digits", 32'(digits), 32'h000000);
        cyc(1);                                   // after N+4
        check_eq("first_tick_digits", 32'(digits), 32'h000001);
        cyc(5);                                   // after N+9
        start_stop = 1'b0;
        check_eq("held_press_once", 32'(running), 32'd1);
        cyc(390);                                 // after N+399
        check_eq("digits_0_99", 32'(digits), 32'h000099);
        cyc(1);                                   // after N+400
        check_eq("digits_1_00", 32'(digits), 32'h000100);

        // Pause, then simultaneous start_stop + clear in PAUSE -> IDLE.
        press_ss();
        check_eq("pause_running", 32'(running), 32'd0);
        check_eq("pause_digits", 32'(digits), 32'h000100);
        cyc(1);
        press_both();
        check_eq("pause_both_running", 32'(running), 32'd0);
        check_eq("pause_both_digits", 32'(digits), 32'h000000);
        cyc(1);

        // Run 6 cycles, pause 50, resume: prescaler held at 2 (edge S start).
        press_ss();                               // after S
        cyc(3);                                   // after S+3
        check_eq("pres_cleared_no_tick", 32'(digits), 32'h000000);
        cyc(1);                                   // after S+4
        check_eq("s4_digits", 32'(digits), 32'h000001);
        cyc(1);                                   // after S+5
        press_ss();                               // after S+6, paused
        check_eq("pause2_running", 32'(running), 32'd0);
        cyc(50);
        check_eq("paused_hold_digits", 32'(digits), 32'h000001);
        press_ss();                               // after R
        check_eq("resume_running", 32'(running), 32'd1);
        cyc(1);                                   // after R+1
        check_eq("resume_r1_digits", 32'(digits), 32'h000001);
        cyc(1);                                   // after R+2
        check_eq("resume_r2_digits", 32'(digits), 32'h000002);

        // Simultaneous presses in RUN -> PAUSE, digits kept; then clear.
        cyc(1);
        press_both();
        check_eq("run_both_running", 32'(running), 32'd0);
        check_eq("run_both_digits", 32'(digits), 32'h000002);
        cyc(1);
        press_clr();
        check_eq("clr_digits", 32'(digits), 32'h000000);
        check_eq("clr_running", 32'(running), 32'd0);
        cyc(1);

        // Rollover: preload 59:59.98 while paused with prescaler at 2.
        press_ss();                               // edge A
        cyc(1);
        press_ss();                               // edge A+2, paused
        force dut.cnt_q = 24'h595998;
        cyc(2);
        release dut.cnt_q;
        cyc(1);
        check_eq("preload_digits", 32'(digits), 32'h595998);
        press_ss();                               // after R2
        cyc(1);                                   // after R2+1
        check_eq("wrap_r1_digits", 32'(digits), 32'h595998);
        cyc(1);                                   // after R2+2
        check_eq("wrap_max_digits", 32'(digits), 32'h595999);
        check_eq("wrap_low_at_max", 32'(wrap), 32'd0);
        cyc(3);                                   // after R2+5
        check_eq("wrap_low_before", 32'(wrap), 32'd0);
        cyc(1);                                   // after R2+6
        check_eq("wrap_zero_digits", 32'(digits), 32'h000000);
        check_eq("wrap_pulse", 32'(wrap), 32'd1);
        cyc(1);
        check_eq("wrap_one_cycle", 32'(wrap), 32'd0);
        check_eq("wrap_still_running", 32'(running), 32'd1);
        cyc(3);                                   // after R2+10
        check_eq("after_wrap_digits", 32'(digits), 32'h000001);

        // Reset mid-run discards everything, including the prescaler.
        reset = 1'b1;
        cyc(1);
        check_eq("midrst_running", 32'(running), 32'd0);
        check_eq("midrst_digits", 32'(digits), 32'h000000);
        reset = 1'b0;
        cyc(1);
        press_ss();                               // edge B
        cyc(3);
        check_eq("postrst_b3_digits", 32'(digits), 32'h000000);
        cyc(1);
        check_eq("postrst_b4_digits", 32'(digits), 32'h000001);
        cyc(1);
        press_ss();
        cyc(1);
        press_clr();
        cyc(1);

`ifdef STOPWATCH_LAP_EN
        // Lap freeze at 00:00.05, 20 more ticks, then release (edge L start).
        press_ss();                               // after L
        cyc(20);                                  // after L+20
        check_eq("lap_pre_digits", 32'(digits), 32'h000005);
        press_lap();                              // after L+21
        check_eq("lap_on", 32'(lap_active), 32'd1);
        cyc(80);                                  // after L+101
        check_eq("lap_frozen_digits", 32'(digits), 32'h000005);
        press_lap();                              // after L+102
        check_eq("lap_release_digits", 32'(digits), 32'h000025);
        check_eq("lap_off", 32'(lap_active), 32'd0);
`else
        // Lap input has no effect.
        press_ss();                               // after L
        cyc(3);
        press_lap();                              // after L+4
        check_eq("nolap_active", 32'(lap_active), 32'd0);
        check_eq("nolap_digits", 32'(digits), 32'h000001);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and timekeeping stage that consumes the debounced button outputs and produces the stopwatch time as BCD digits for the display driver. It converts each debounced level into a single-cycle press event and runs an IDLE/RUN/PAUSE state machine. While running, it divides the system clock down to a 100 Hz tick and advances a mm:ss.cc BCD counter.

## Interface
Parameters:
- TICK_DIV, 1_000_000 — clk cycles per hundredth of a second; legal values are ≥ 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_stop  in  1  debounced start/stop button level
- clear  in  1  debounced clear button level
- lap  in  1  debounced lap button level; used only when `STOPWATCH_LAP_EN` is defined, ignored otherwise
- running  out  1  high while in RUN
- digits  out  24  BCD digits [23:20] min tens … [3:0] centisecond ones
- wrap  out  1  one-cycle pulse on rollover 59:59.99 → 00:00.00
- lap_active  out  1  display frozen; tied to 0 without `STOPWATCH_LAP_EN`

## Operation
Edge detection:
- Each button input has a `prev` register that resets to 1, so a button held through reset does not produce a press.
- press = in & ~prev; prev <= in every cycle.
- A level held for many cycles yields exactly one press.

State machine (states IDLE, RUN, PAUSE; reset → IDLE):
- IDLE: start_stop press → RUN; clear press has no effect.
- RUN: start_stop press → PAUSE; clear press is ignored.
- PAUSE: start_stop press → RUN. Clear press → IDLE, which zeroes the time counter and the prescaler.
- Simultaneous start_stop and clear presses: in PAUSE, clear wins and the next state is IDLE. In IDLE and RUN, start_stop acts and clear is ignored.

Prescaler:
- Counts 0 … TICK_DIV-1, advancing only in RUN.
- tick = (prescaler == TICK_DIV-1) & RUN; the prescaler returns to 0 on tick.
- Held in PAUSE so the partial hundredth is kept. Cleared on reset and on the PAUSE→IDLE transition.

Time counter (six BCD digits, updated on tick):
- Centisecond ones and seconds ones count 0–9.
- Centisecond tens counts 0–9; seconds tens and minutes tens count 0–5; minutes ones counts 0–9.
- The full carry chain resolves within a single cycle.
- At 59:59.99 a tick gives 00:00.00 and asserts wrap for that one cycle. Counting continues in RUN.
- digits shows the live counter unless it is frozen (see Configuration).

## Timing
Reset values:
- running=0, digits=24'h000000, wrap=0, lap_active=0.
- State is IDLE, the prescaler is 0, and all prev registers are 1.

Latency:
- An input first sampled high at clock edge N updates the state and running at edge N. The new value is visible after that edge.
- Entering RUN at edge N gives the first tick at edge N+TICK_DIV. digits changes at that edge.
- A start_stop press coincident with a tick: the tick is applied first, then the state changes to PAUSE.

Reset mid-operation:
- Asserting reset in any state returns all registers to their reset values at the next edge.
- Asserting reset discards any partial count.

## Configuration
`STOPWATCH_LAP_EN` defined:
- A lap press in RUN or PAUSE toggles lap_active.
- While lap_active=1, a display register captures the counter value at the press. digits shows that register while the counter keeps running underneath.
- A lap press in IDLE is ignored.
- The PAUSE→IDLE transition forces lap_active=0.

`STOPWATCH_LAP_EN` not defined:
- The lap input is unused and lap_active is the constant 0.
- digits is driven directly from the counter, with no display register.

## Test plan
All scenarios use TICK_DIV=4.
- Reset with start_stop held high, then release reset and keep the input high → state stays IDLE, running=0, digits=000000.
- Start_stop pulse held 10 cycles → one press only; running=1. After 4 cycles digits=000001; after 400 cycles from start, digits=000100.
- RUN for 6 cycles, pause, wait 50 cycles, resume → no digit change while paused. The next tick arrives 2 cycles after resume (the prescaler was held).
- Preload by running to 59:59.98 (or force), then two ticks → 59:59.99, then 000000 with wrap=1 for exactly one cycle.
- In PAUSE, press start_stop and clear on the same cycle → IDLE, digits=000000, running=0. In RUN, the same stimulus → PAUSE with digits unchanged.
- `STOPWATCH_LAP_EN` defined: lap press at 00:00.05, run 20 more ticks → digits holds 000005. A second lap press → digits=000025, lap_active=0.
